sp_bram_be_clr: RTL

Parametrised single-port block RAM built by inference, with per-byte write enables, selectable read-during-write mode and an optional output register stage. A read-valid pipeline tags returned data. A built-in clear sequencer loads a constant into every location after reset or on request. It is the general-purpose single-port buffer for datapath blocks that need byte-lane updates and a known memory state without a software init pass.

---
 rtl/sp_bram_be_clr.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sp_bram_be_clr.sv
// Single-port inferred block RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and a built-in
// clear sequencer that fills the array with a constant after reset or on
// request. While the sequencer runs, user accesses are ignored.
module sp_bram_be_clr #(
  parameter int                 G_ADDR       = 6,
  parameter int                 G_WIDTH      = 16,
  parameter int                 G_BYTE       = 8,
  parameter string              G_MODE       = "NO_CHANGE",
  parameter int                 G_OREG       = 0,
  parameter int                 G_CLR_ON_RST = 1,
  parameter logic [G_WIDTH-1:0] G_INIT_VAL   = '0,
  localparam int                G_NBE        = G_WIDTH / G_BYTE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  output logic               busy,
  input  logic               en,
  input  logic [G_NBE-1:0]   we,
  input  logic [G_ADDR-1:0]  addr,
  input  logic [G_WIDTH-1:0] din,
  output logic [G_WIDTH-1:0] dout,
  output logic               dout_vld
);

  localparam int DEPTH = 2 ** G_ADDR;

  // Read-during-write selection; anything unrecognised behaves as NO_CHANGE.
  localparam int MODE_NC = 0;
  localparam int MODE_RF = 1;
  localparam int MODE_WF = 2;
  localparam int MODE_SEL = (G_MODE == "READ_FIRST")  ? MODE_RF :
                            (G_MODE == "WRITE_FIRST") ? MODE_WF : MODE_NC;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RST   = (G_CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  localparam logic [G_ADDR-1:0] CNT_LAST = '1;

  genvar gi;

  // Byte lanes must tile the word exactly.
  generate
    if ((G_WIDTH % G_BYTE) != 0) begin : g_bad_width
      $error("sp_bram_be_clr: G_WIDTH must be an integer multiple of G_BYTE");
    end
  endgenerate

  logic [G_WIDTH-1:0] mem [0:DEPTH-1];

  logic [0:0]         state_q, state_d;
  logic [G_ADDR-1:0]  cnt_q, cnt_d;
  logic [G_WIDTH-1:0] dout1_q, dout1_d;
  logic               vld1_q, vld1_d;

  logic               acc;
  logic               is_wr;
  logic [G_WIDTH-1:0] rd_word;
  logic [G_WIDTH-1:0] merged_word;
  logic [G_NBE-1:0]   wr_lane;
  logic [G_ADDR-1:0]  wr_addr;
  logic [G_WIDTH-1:0] wr_data;

  assign busy    = (state_q == ST_CLEAR);
  assign acc     = en & ~busy;
  assign is_wr   = |we;
  assign rd_word = mem[addr];

  // Word as it looks after the write: enabled lanes from din, others retained.
  generate
    for (gi = 0; gi < G_NBE; gi++) begin : g_lane
      assign merged_word[gi*G_BYTE +: G_BYTE] =
        we[gi] ? din[gi*G_BYTE +: G_BYTE] : rd_word[gi*G_BYTE +: G_BYTE];
    end
  endgenerate

  // Clear sequencer: walk every address once, then drop back to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single write port shared by the clear sequencer and user writes.
  always_comb begin
    wr_lane = '0;
    wr_addr = addr;
    wr_data = din;
    if (busy) begin
      wr_lane = '1;
      wr_addr = cnt_q;
      wr_data = G_INIT_VAL;
    end else if (acc && is_wr) begin
      wr_lane = we;
    end
  end

  // Stage-1 read result: data and its valid tag for this access.
  always_comb begin
    dout1_d = dout1_q;
    vld1_d  = 1'b0;
    if (acc) begin
      if (!is_wr) begin
        dout1_d = rd_word;
        vld1_d  = 1'b1;
      end else begin
        case (MODE_SEL)
          MODE_RF: begin
            dout1_d = rd_word;
            vld1_d  = 1'b1;
          end
          MODE_WF: begin
            dout1_d = merged_word;
            vld1_d  = 1'b1;
          end
          default: begin
            dout1_d = dout1_q;
            vld1_d  = 1'b0;
          end
        endcase
      end
    end
  end

  // Memory array: byte-lane writes, contents never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < G_NBE; i++) begin
      if (wr_lane[i]) begin
        mem[wr_addr][i*G_BYTE +: G_BYTE] <= wr_data[i*G_BYTE +: G_BYTE];
      end
    end
  end

  // Control state and stage-1 output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      dout1_q <= '0;
      vld1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout1_q <= dout1_d;
      vld1_q  <= vld1_d;
    end
  end

  generate
    if (G_OREG != 0) begin : g_oreg
      logic [G_WIDTH-1:0] dout2_q, dout2_d;
      logic               vld2_q, vld2_d;

      // Second stage simply follows stage 1, adding one cycle of latency.
      always_comb begin
        dout2_d = dout1_q;
        vld2_d  = vld1_q;
      end

      // Output register stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout2_q <= '0;
          vld2_q  <= 1'b0;
        end else begin
          dout2_q <= dout2_d;
          vld2_q  <= vld2_d;
        end
      end

      assign dout     = dout2_q;
      assign dout_vld = vld2_q;
    end else begin : g_noreg
      assign dout     = dout1_q;
      assign dout_vld = vld1_q;
    end
  endgenerate

endmodule
